// File: rtl/blk2raster_sched.sv
// Frame sequencer: writes an 8x8-block-ordered pixel stream into a frame buffer at
// raster addresses, then reads the buffer back out in raster order.
module blk2raster_sched #(
    parameter int IMG_W  = 320,
    parameter int IMG_H  = 240,
    parameter int ADDR_W = 17,
    parameter int DATA_W = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              en_i,
    input  logic              start_i,
    input  logic [DATA_W-1:0] pix_i,
    input  logic              pix_valid_i,
    output logic              pix_ready_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_waddr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic              mem_re_o,
    output logic [ADDR_W-1:0] mem_raddr_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic [DATA_W-1:0] pix_o,
    output logic              pix_valid_o,
    input  logic              pix_ready_i,
    output logic              busy_o,
    output logic              done_o
);
    localparam int BLK_COLS = IMG_W / 8;
    localparam int BC_W     = (BLK_COLS > 1) ? $clog2(BLK_COLS) : 1;
    localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] BAND_STEP = ADDR_W'(8 * IMG_W);
    localparam logic [ADDR_W-1:0] LAST_BAND = ADDR_W'((IMG_H - 8) * IMG_W);
    localparam logic [ADDR_W-1:0] LAST_PIX  = ADDR_W'(IMG_W * IMG_H - 1);
    localparam logic [BC_W-1:0]   LAST_BC   = BC_W'(BLK_COLS - 1);

    typedef enum logic [2:0] {IDLE, LOAD, RD_REQ, RD_WAIT, OUT, DONE} state_t;
    state_t state, state_nx;

    logic [2:0]        col_c, row_c;
    logic [BC_W-1:0]   blk_c;
    logic [ADDR_W-1:0] band_base, row_off, col_off;
    logic [ADDR_W-1:0] rd_cnt;
    logic              vld_p1;
    logic [ADDR_W-1:0] waddr_p1;
    logic [DATA_W-1:0] wdata_p1;
    logic [DATA_W-1:0] rdata_p1;
    logic              in_acc, last_beat;

    assign in_acc    = en_i && (state == LOAD) && pix_valid_i;
    assign last_beat = (col_c == 3'd7) && (row_c == 3'd7) && (blk_c == LAST_BC)
                       && (band_base == LAST_BAND);

    always_ff @(posedge clk_i) begin
        if (!rst_i)
            state <= IDLE;
        else if (en_i)
            state <= state_nx;
    end

    always_comb begin
        state_nx    = state;
        pix_ready_o = 1'b0;
        mem_re_o    = 1'b0;
        pix_valid_o = 1'b0;
        done_o      = 1'b0;
        busy_o      = (state != IDLE);
        case (state)
            IDLE:    if (start_i) state_nx = LOAD;
            LOAD: begin
                pix_ready_o = en_i;
                if (pix_valid_i && last_beat) state_nx = RD_REQ;
            end
            RD_REQ: begin
                mem_re_o = en_i;
                state_nx = RD_WAIT;
            end
            RD_WAIT: state_nx = OUT;
            OUT: begin
                pix_valid_o = en_i;
                if (pix_ready_i) state_nx = (rd_cnt == LAST_PIX) ? DONE : RD_REQ;
            end
            DONE: begin
                done_o   = en_i;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // Stage p0: block-order position -> raster address via nested wrap counters.
    // Each counter wraps back to zero after the last beat, ready for the next frame.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            col_c     <= 3'd0;
            row_c     <= 3'd0;
            blk_c     <= '0;
            band_base <= '0;
            row_off   <= '0;
            col_off   <= '0;
        end else if (in_acc) begin
            if (col_c != 3'd7) begin
                col_c <= col_c + 3'd1;
            end else begin
                col_c <= 3'd0;
                if (row_c != 3'd7) begin
                    row_c   <= row_c + 3'd1;
                    row_off <= row_off + ROW_STEP;
                end else begin
                    row_c   <= 3'd0;
                    row_off <= '0;
                    if (blk_c != LAST_BC) begin
                        blk_c   <= blk_c + BC_W'(1);
                        col_off <= col_off + ADDR_W'(8);
                    end else begin
                        blk_c     <= '0;
                        col_off   <= '0;
                        band_base <= (band_base == LAST_BAND) ? '0 : band_base + BAND_STEP;
                    end
                end
            end
        end
    end

    // Stage p1: registered RAM write.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            vld_p1   <= 1'b0;
            waddr_p1 <= '0;
            wdata_p1 <= '0;
        end else if (en_i) begin
            vld_p1 <= in_acc;
            if (in_acc) begin
                waddr_p1 <= band_base + row_off + col_off + ADDR_W'(col_c);
                wdata_p1 <= pix_i;
            end
        end
    end

    assign mem_we_o    = en_i && vld_p1;
    assign mem_waddr_o = waddr_p1;
    assign mem_wdata_o = wdata_p1;

    // Read side: sequential raster counter, RAM data captured one cycle after the request.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            rd_cnt   <= '0;
            rdata_p1 <= '0;
        end else if (en_i) begin
            if (state == RD_WAIT)
                rdata_p1 <= mem_rdata_i;
            if (state == OUT && pix_ready_i && rd_cnt != LAST_PIX)
                rd_cnt <= rd_cnt + ADDR_W'(1);
            if (state == DONE)
                rd_cnt <= '0;
        end
    end

    assign mem_raddr_o = rd_cnt;
    assign pix_o       = rdata_p1;
endmodule

// File: doc/blk2raster_sched.md
Name: blk2raster_sched

Overview:
- Frame-level controller that sequences one 8x8-block-to-raster reordering pass over a frame buffer.
- Accepts a pixel stream in 8x8 block order (blocks left-to-right, then top-to-bottom; pixels row-major inside a block).
- Writes each pixel to its raster address in an external single-port-write/single-port-read RAM, then drains the RAM in raster order as an output stream.
- Replaces ad-hoc per-module state sequencing with explicit valid/ready handshakes on both sides.

Parameters:
- IMG_W, 320, image width in pixels; multiple of 8.
- IMG_H, 240, image height in pixels; multiple of 8.
- ADDR_W, 17, frame-buffer address width; 2^ADDR_W >= IMG_W*IMG_H.
- DATA_W, 8, pixel width.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  reset, synchronous, active-low.
- en_i  in  1  global enable; 0 freezes all state.
- start_i  in  1  start one frame pass (sampled in IDLE only).
- pix_i  in  DATA_W  input pixel, block order.
- pix_valid_i  in  1  input beat valid.
- pix_ready_o  out  1  input beat accepted when valid&ready.
- mem_we_o  out  1  RAM write strobe.
- mem_waddr_o  out  ADDR_W  RAM write address.
- mem_wdata_o  out  DATA_W  RAM write data.
- mem_re_o  out  1  RAM read strobe.
- mem_raddr_o  out  ADDR_W  RAM read address.
- mem_rdata_i  in  DATA_W  RAM read data, valid 1 cycle after mem_re_o.
- pix_o  out  DATA_W  output pixel, raster order.
- pix_valid_o  out  1  output beat valid.
- pix_ready_i  in  1  downstream accept.
- busy_o  out  1  high in any state other than IDLE.
- done_o  out  1  one-cycle pulse at frame completion.

Behaviour:
- Reset (rst_i=0 at clock edge) forces:
  - state IDLE.
  - All counters 0.
  - All outputs 0: pix_ready_o, mem_we_o, mem_re_o, pix_valid_o, busy_o, done_o, addresses, data.
  - Reset mid-frame discards the frame; no further RAM writes or output beats occur.
- en_i=0:
  - No state, counter or output register changes.
  - pix_ready_o, mem_we_o and mem_re_o are gated to 0.
  - pix_valid_o is gated to 0; the held beat reappears when en_i returns to 1.
- States: IDLE, LOAD, RD_REQ, RD_WAIT, OUT, DONE.
- IDLE -> LOAD: on start_i=1. start_i in any other state is ignored.
- LOAD:
  - pix_ready_o=1.
  - Each accepted beat n (0..N-1, N=IMG_W*IMG_H) is decomposed as c=n[2:0], r=n[5:3], b=n>>6, bc=b mod (IMG_W/8), br=b div (IMG_W/8).
  - Raster address = (br*8+r)*IMG_W + bc*8 + c.
  - Implement with nested wrap counters (c, r, bc, br) and incremental row-base/column-offset registers. No dividers or multipliers by non-constant values.
  - Write is registered: a beat accepted at cycle t drives mem_we_o=1 and mem_waddr_o/mem_wdata_o at t+1.
  - After beat N-1 is accepted, pix_ready_o drops the next cycle and the state moves to RD_REQ. The final write still issues at t+1.
- RD_REQ: mem_re_o=1, mem_raddr_o=read counter (0..N-1, sequential).
- RD_WAIT: capture mem_rdata_i into pix_o; set pix_valid_o=1; go to OUT.
- OUT: hold pix_o and pix_valid_o until pix_ready_i=1. On acceptance:
  - if the read counter is N-1, go to DONE;
  - else increment the read counter and go to RD_REQ.
  - Peak rate is one output beat per 3 cycles.
- DONE: done_o=1 for exactly one cycle, then IDLE. busy_o falls the same cycle state enters IDLE.
- Counters wrap to 0 on entry to IDLE; a new start_i produces an identical pass.
- Input beats presented outside LOAD are not accepted (pix_ready_o=0).

Test Plan:
- Defaults; start, stream N=76800 beats with pix_i=n[7:0], continuous valid -> write addresses: beat 0->0, 7->7, 8->320, 63->2247, 64->8, 2559->2559, 2560->2560, 76799->76799; exactly 76800 mem_we_o pulses.
- IMG_W=16, IMG_H=8, input beats value=n -> raster output sequence 0..7, 64..71, 8..15, 72..79, ... ; 128 output beats; done_o pulses once, 1 cycle after the last acceptance.
- Random pix_valid_i gaps and random pix_ready_i stalls -> no lost or duplicated beats; pix_o stable while pix_valid_o=1 and pix_ready_i=0.
- en_i=0 for 5 cycles mid-LOAD and mid-OUT -> counters, addresses and pix_o unchanged; strobes and valid gated 0; stream resumes correctly.
- rst_i=0 for 1 cycle at beat 1000 of LOAD -> all outputs 0, busy_o=0; next start_i gives a clean full pass from address 0.
- start_i pulsed during RD_REQ/OUT -> ignored; exactly one done_o per frame.
